// File: rtl/mod_pkg.sv
// Shared definitions for the programmable modulo-N counter: FSM state
// encodings and the smallest modulus the counter accepts.
package mod_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int MOD_MIN = 2;

endpackage

// File: rtl/mod_n_prog.sv
// Runtime-programmable modulo-N counter with up/down, load, one-shot mode,
// terminal-count decode and wrap pulse. Cascade by feeding tc into the next
// stage's en.
//
// Control inputs are level-sampled at each posedge and take effect in the
// next cycle. Per-cycle priority: rst > mod_wr > load > stop/start > count.
module mod_n_prog #(
  parameter int WIDTH = 4,
  parameter int N_RST = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             oneshot,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH:0]   mod,
  output logic             tc,
  output logic             wrap,
  output logic             busy,
  output logic             mod_err
);

  import mod_pkg::*;

  // The reset modulus must be a legal modulus for this width.
  if (N_RST < MOD_MIN || N_RST > (1 << WIDTH)) begin : g_bad_n_rst
    $error("mod_n_prog: N_RST out of range 2..2^WIDTH");
  end

  localparam logic [WIDTH:0]   MOD_LO  = (WIDTH+1)'(MOD_MIN);
  localparam logic [WIDTH:0]   MOD_HI  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   MOD_RST = (WIDTH+1)'(N_RST);
  localparam logic [WIDTH:0]   MOD_ONE = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH:0]   mod_q, mod_d;
  logic             wrap_q, wrap_d;
  logic             mod_err_q, mod_err_d;

  logic [WIDTH:0]   count_w;
  logic [WIDTH:0]   mod_m1;
  logic [WIDTH:0]   new_mod_m1;
  logic             mod_val_ok;

  // Comparisons run in WIDTH+1 bits so a modulus of 2^WIDTH uses the full range.
  assign count_w    = {1'b0, count_q};
  assign mod_m1     = mod_q - MOD_ONE;
  assign mod_val_ok = (mod_val >= MOD_LO) && (mod_val <= MOD_HI);

  // Next-state, next-count, modulus update and wrap generation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mod_d      = mod_q;
    wrap_d     = 1'b0;
    mod_err_d  = mod_err_q;
    new_mod_m1 = '0;

    // A legal modulus write restarts from 0 in IDLE; an illegal one only flags.
    if (mod_wr) begin
      if (mod_val_ok) begin
        mod_d   = mod_val;
        count_d = '0;
        state_d = S_IDLE;
      end else begin
        mod_err_d = 1'b1;
      end
    end

    if (load) begin
      // Clamp against the modulus in force after this cycle's write.
      new_mod_m1 = mod_d - MOD_ONE;
      if ({1'b0, load_val} < mod_d) begin
        count_d = load_val;
      end else begin
        count_d = new_mod_m1[WIDTH-1:0];
      end
    end else if (!mod_wr) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (en) begin
            if (up) begin
              if (count_w == mod_m1) begin
                count_d = '0;
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q + CNT_ONE;
              end
            end else begin
              if (count_q == '0) begin
                count_d = mod_m1[WIDTH-1:0];
                wrap_d  = 1'b1;
              end else begin
                count_d = count_q - CNT_ONE;
              end
            end
            if (wrap_d && oneshot) state_d = S_DONE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, count, modulus and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      mod_q     <= MOD_RST;
      wrap_q    <= 1'b0;
      mod_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mod_q     <= mod_d;
      wrap_q    <= wrap_d;
      mod_err_q <= mod_err_d;
    end
  end

  assign count   = count_q;
  assign mod     = mod_q;
  assign wrap    = wrap_q;
  assign mod_err = mod_err_q;
  assign busy    = (state_q == S_RUN);
  assign tc      = up ? (count_w == mod_m1) : (count_q == '0);

endmodule

// File: tb/tb_mod_n_prog.sv
// Bench for mod_n_prog (WIDTH=4, N_RST=12). Expected {count,wrap,busy,tc}
// tuples are queued as each cycle's stimulus is driven and popped after the
// following posedge.
module tb_mod_n_prog;

  localparam int WIDTH = 4;
  localparam int N_RST = 12;
  localparam int W     = WIDTH + 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             en, up, oneshot, start, stop, load, mod_wr;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   mod_val;
  logic [WIDTH-1:0] count;
  logic [WIDTH:0]   mod;
  logic             tc, wrap, busy, mod_err;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, exp_v;
  int errors = 0;
  int checks = 0;

  mod_n_prog #(.WIDTH(WIDTH), .N_RST(N_RST)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .oneshot(oneshot),
    .start(start), .stop(stop), .load(load), .load_val(load_val),
    .mod_wr(mod_wr), .mod_val(mod_val), .count(count), .mod(mod),
    .tc(tc), .wrap(wrap), .busy(busy), .mod_err(mod_err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack(input int c, input logic w,
                                        input logic b, input logic t);
    return {WIDTH'(c), w, b, t};
  endfunction

  // Driver tasks: inputs change 1 time unit after the posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; up = 1'b1; oneshot = 1'b0; start = 1'b0; stop = 1'b0;
    load = 1'b0; load_val = '0; mod_wr = 1'b0; mod_val = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset(2);
    checks++;
    if (count !== 4'd0 || mod !== 5'd12 || busy !== 1'b0 || wrap !== 1'b0 ||
        mod_err !== 1'b0 || tc !== 1'b0) begin
      errors++;
      $display("FAIL reset: count=%0d mod=%0d busy=%b wrap=%b mod_err=%b tc=%b, want 0 12 0 0 0 0",
               count, mod, busy, wrap, mod_err, tc);
    end
  endtask

  task automatic test_count_up();
    int c;
    idle_inputs();
    do_reset(2);
    en = 1'b1; up = 1'b1; start = 1'b1;
    exp_q.push_back(pack(0, 1'b0, 1'b1, 1'b0));
    tick();
    start = 1'b0;
    got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL up_start: got=%b want=%b", got, exp_v); end
    for (int i = 1; i <= 14; i++) begin
      c = i % 12;
      exp_q.push_back(pack(c, c == 0, 1'b1, c == 11));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL count_up step %0d: got=%b want=%b", i, got, exp_v); end
    end
  endtask

  task automatic test_count_down();
    int c;
    idle_inputs();
    do_reset(1);
    en = 1'b1; up = 1'b0; start = 1'b1;
    exp_q.push_back(pack(0, 1'b0, 1'b1, 1'b1));
    tick();
    start = 1'b0;
    got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL down_start: got=%b want=%b", got, exp_v); end
    for (int i = 1; i <= 13; i++) begin
      c = (12 - (i % 12)) % 12;
      exp_q.push_back(pack(c, c == 11, 1'b1, c == 0));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL count_down step %0d: got=%b want=%b", i, got, exp_v); end
    end
  endtask

  task automatic test_oneshot();
    idle_inputs();
    do_reset(1);
    en = 1'b1; up = 1'b1; oneshot = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 12) exp_q.push_back(pack(0, 1'b1, 1'b0, 1'b0));
      else         exp_q.push_back(pack(i, 1'b0, 1'b1, i == 11));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL oneshot step %0d: got=%b want=%b", i, got, exp_v); end
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pack(0, 1'b0, 1'b0, 1'b0));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL oneshot_hold %0d: got=%b want=%b", i, got, exp_v); end
    end
    start = 1'b1;
    exp_q.push_back(pack(0, 1'b0, 1'b1, 1'b0));
    tick();
    start = 1'b0;
    exp_q.push_back(pack(1, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(pack(2, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL oneshot_restart %0d: got=%b want=%b", i, got, exp_v); end
      if (i < 2) tick();
    end
  endtask

  task automatic test_mod_write();
    idle_inputs();
    do_reset(1);
    mod_wr = 1'b1; mod_val = 5'd16;
    tick();
    mod_wr = 1'b0;
    checks++;
    if (mod !== 5'd16 || count !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mod_wr16: mod=%0d count=%0d busy=%b, want 16 0 0", mod, count, busy);
    end
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(pack(i % 16, i == 16, 1'b1, i == 15));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL mod16 step %0d: got=%b want=%b", i, got, exp_v); end
    end
    mod_wr = 1'b1; mod_val = 5'd1;
    tick();
    checks++;
    if (mod !== 5'd16 || mod_err !== 1'b1 || count !== 4'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL mod_wr1: mod=%0d err=%b count=%0d busy=%b, want 16 1 0 1", mod, mod_err, count, busy);
    end
    mod_val = 5'd17;
    tick();
    mod_wr = 1'b0;
    checks++;
    if (mod !== 5'd16 || mod_err !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL mod_wr17: mod=%0d err=%b count=%0d, want 16 1 0", mod, mod_err, count);
    end
    tick();
    checks++;
    if (count !== 4'd1 || mod_err !== 1'b1) begin
      errors++; $display("FAIL err_sticky: count=%0d err=%b, want 1 1", count, mod_err);
    end
    do_reset(1);
    checks++;
    if (mod_err !== 1'b0 || mod !== 5'd12) begin
      errors++; $display("FAIL err_clear: err=%b mod=%0d, want 0 12", mod_err, mod);
    end
  endtask

  task automatic test_load();
    idle_inputs();
    do_reset(1);
    load = 1'b1; load_val = 4'd9;
    tick();
    checks++;
    if (count !== 4'd9 || busy !== 1'b0) begin
      errors++; $display("FAIL load9: count=%0d busy=%b, want 9 0", count, busy);
    end
    load_val = 4'd14;
    tick();
    load = 1'b0;
    checks++;
    if (count !== 4'd11) begin
      errors++; $display("FAIL load14_clamp: count=%0d, want 11", count);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    mod_wr = 1'b1; mod_val = 5'd5; load = 1'b1; load_val = 4'd7;
    tick();
    mod_wr = 1'b0; load = 1'b0;
    checks++;
    if (mod !== 5'd5 || count !== 4'd4 || busy !== 1'b0 || wrap !== 1'b0 || tc !== 1'b1) begin
      errors++; $display("FAIL modwr_load: mod=%0d count=%0d busy=%b wrap=%b tc=%b, want 5 4 0 0 1",
                         mod, count, busy, wrap, tc);
    end
  endtask

  task automatic test_enable_and_rst();
    idle_inputs();
    do_reset(1);
    en = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    checks++;
    if (count !== 4'd7 || busy !== 1'b1) begin
      errors++; $display("FAIL run_to_7: count=%0d busy=%b, want 7 1", count, busy);
    end
    do_reset(1);
    checks++;
    if (count !== 4'd0 || mod !== 5'd12 || busy !== 1'b0 || wrap !== 1'b0 || mod_err !== 1'b0) begin
      errors++; $display("FAIL mid_rst: count=%0d mod=%0d busy=%b wrap=%b err=%b, want 0 12 0 0 0",
                         count, mod, busy, wrap, mod_err);
    end
    en = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pack(0, 1'b0, 1'b1, 1'b0));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL en0_hold %0d: got=%b want=%b", i, got, exp_v); end
    end
    for (int i = 0; i < 8; i++) begin
      en = i[0];
      exp_q.push_back(pack((i + 1) / 2, 1'b0, 1'b1, 1'b0));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL en_toggle %0d: got=%b want=%b", i, got, exp_v); end
    end
    en = 1'b1; stop = 1'b1; start = 1'b1;
    exp_q.push_back(pack(4, 1'b0, 1'b0, 1'b0));
    tick();
    stop = 1'b0; start = 1'b0;
    got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL stop_wins: got=%b want=%b", got, exp_v); end
    tick();
    checks++;
    if (count !== 4'd4 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_hold: count=%0d busy=%b, want 4 0", count, busy);
    end
  endtask

  task automatic test_random_load();
    int lv;
    idle_inputs();
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      lv = $urandom_range(0, 15);
      load = 1'b1; load_val = WIDTH'(lv);
      exp_q.push_back(pack((lv < 12) ? lv : 11, 1'b0, 1'b0, (lv >= 11)));
      tick();
      got = {count, wrap, busy, tc}; exp_v = exp_q.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL rand_load %0d val=%0d: got=%b want=%b", i, lv, got, exp_v); end
    end
    load = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_count_up();
    test_count_down();
    test_oneshot();
    test_mod_write();
    test_load();
    test_enable_and_rst();
    test_random_load();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_n_prog.md
Name: mod_n_prog

Overview:
Parametrised, runtime-programmable modulo-N counter. Extends the fixed mod-N up-counter with up/down direction, load, a runtime-writable modulus, a one-shot mode with a small control FSM, and wrap/terminal-count flags. Used as the common timebase/divider block for baud ticks, refresh timers and frame counters. Several instances may be cascaded via tc/en.

Parameters:
WIDTH, 4, count width in bits
N_RST, 10, modulus loaded at reset; legal range 2..2^WIDTH (elaboration error otherwise)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset; one clock; reset is synchronous and active-high
en  in  1  count enable; counter advances only in RUN with en=1
up  in  1  direction: 1=up, 0=down; sampled every cycle
oneshot  in  1  1=stop in DONE after first wrap; 0=free-run
start  in  1  IDLE/DONE -> RUN; ignored in RUN
stop  in  1  RUN -> IDLE; count held
load  in  1  synchronous load of load_val
load_val  in  WIDTH  value to load
mod_wr  in  1  write new modulus
mod_val  in  WIDTH+1  new modulus
count  out  WIDTH  current count, registered
mod  out  WIDTH+1  current modulus, registered
tc  out  1  combinational decode: count==mod-1 when up=1, count==0 when up=0
wrap  out  1  registered one-cycle pulse, high in the cycle the wrapped value appears on count
busy  out  1  high in RUN
mod_err  out  1  sticky: illegal modulus write attempted; cleared only by rst

Behaviour:
- Reset values: count=0, mod=N_RST, state=IDLE, busy=0, wrap=0, mod_err=0.
- FSM states: IDLE, RUN, DONE. IDLE -start-> RUN. RUN -stop-> IDLE. RUN -wrap with oneshot=1-> DONE. DONE -start-> RUN. start and stop together in RUN: stop wins.
- Counting (RUN, en=1, no load/mod_wr): up: count==mod-1 -> 0 with wrap, else count+1. Down: count==0 -> mod-1 with wrap, else count-1. Compare in WIDTH+1 bits so mod=2^WIDTH gives full binary range.
- In IDLE/DONE, or with en=0, count holds and wrap=0.
- One-shot: the wrapping step is taken (count shows 0 up / mod-1 down, wrap=1), then the FSM sits in DONE holding that value.
- Priority per cycle: rst > mod_wr > load > stop/start > count.
- mod_wr with 2<=mod_val<=2^WIDTH: mod<=mod_val, count<=0, state<=IDLE, no wrap. Any other value: write ignored, mod_err<=1, state and count unchanged (load in the same cycle still applies).
- load: count<=load_val if load_val<mod (using the new modulus when mod_wr is in the same cycle), else count<=mod-1 (clamp). State unchanged, no wrap, and no count step that cycle.
- Invariant: count<mod always.
- Latency: every control input takes effect at the next posedge. tc follows count combinationally.

Decomposition:
- Shared package/include mod_pkg: FSM state encodings (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and a MOD_MIN=2 constant.
- No sub-module. Next-count and FSM logic stay inline in a single module.

Test Plan:
1. WIDTH=4, N_RST=12: rst 2 cycles, start, en=1, up=1, oneshot=0 -> count 0..11,0,1; wrap=1 only when count returns to 0; tc=1 at 11; busy=1.
2. Same setup with up=0 from count 0 -> count 11,10,...,0,11; wrap at each 0->11; tc=1 at 0.
3. oneshot=1, up=1, start, 12 enabled cycles -> count 0 with wrap=1, busy=0 (DONE), count holds 0 for 5 cycles; start -> counting resumes 1,2.
4. mod_wr 16 -> mod=16, count 0, IDLE; start -> 0..15,0. mod_wr 1 -> mod stays 16, mod_err=1; mod_wr 17 -> ignored, mod_err stays 1 until rst.
5. mod=12: load 9 -> count 9. Load 14 -> count 11. mod_wr 5 with load 7 same cycle -> mod=5, count 4, state IDLE.
6. Running at count 7: rst -> next edge count 0, mod 12, IDLE, wrap/mod_err 0. en=0 in RUN -> count holds; en toggled every other cycle -> advances only on en=1 cycles.
